// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle RV32IM control unit:
// ALU operation codes, major opcodes and FSM state encodings.
package multicycle_control_pkg;

    localparam logic [4:0] OPADD    = 5'd0;
    localparam logic [4:0] OPSUB    = 5'd1;
    localparam logic [4:0] OPSLL    = 5'd2;
    localparam logic [4:0] OPSLT    = 5'd3;
    localparam logic [4:0] OPSLTU   = 5'd4;
    localparam logic [4:0] OPXOR    = 5'd5;
    localparam logic [4:0] OPSRL    = 5'd6;
    localparam logic [4:0] OPSRA    = 5'd7;
    localparam logic [4:0] OPOR     = 5'd8;
    localparam logic [4:0] OPAND    = 5'd9;
    localparam logic [4:0] OPMUL    = 5'd10;
    localparam logic [4:0] OPMULH   = 5'd11;
    localparam logic [4:0] OPMULHSU = 5'd12;
    localparam logic [4:0] OPMULHU  = 5'd13;
    localparam logic [4:0] OPDIV    = 5'd14;
    localparam logic [4:0] OPDIVU   = 5'd15;
    localparam logic [4:0] OPREM    = 5'd16;
    localparam logic [4:0] OPREMU   = 5'd17;
    localparam logic [4:0] OPBEQ    = 5'd18;
    localparam logic [4:0] OPBNE    = 5'd19;
    localparam logic [4:0] OPGE     = 5'd20;
    localparam logic [4:0] OPGEU    = 5'd21;
    localparam logic [4:0] OPLUI    = 5'd22;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_WB_ALU   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    function automatic logic is_div_op(input logic [4:0] op);
        return op inside {OPDIV, OPDIVU, OPREM, OPREMU};
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: the control unit is the
// master (drives ALU op and enables), the datapath the slave.
interface multicycle_control_if;

    logic [31:0] iInstr;
    logic        iZero;
    logic        iMemReady;
    logic [4:0]  oALUControl;
    logic [1:0]  oALUSrcA;
    logic [1:0]  oALUSrcB;
    logic        oIRWrite;
    logic        oPCWrite;
    logic        oPCSource;
    logic        oMemRead;
    logic        oMemWrite;
    logic        oIorD;
    logic        oRegWrite;
    logic [1:0]  oMemtoReg;
    logic        oIllegal;
    logic [3:0]  oState;

    modport master (
        input  iInstr, iZero, iMemReady,
        output oALUControl, oALUSrcA, oALUSrcB,
        output oIRWrite, oPCWrite, oPCSource,
        output oMemRead, oMemWrite, oIorD,
        output oRegWrite, oMemtoReg,
        output oIllegal, oState
    );

    modport slave (
        output iInstr, iZero, iMemReady,
        input  oALUControl, oALUSrcA, oALUSrcB,
        input  oIRWrite, oPCWrite, oPCSource,
        input  oMemRead, oMemWrite, oIorD,
        input  oRegWrite, oMemtoReg,
        input  oIllegal, oState
    );

endinterface

// File: rtl/multicycle_control_alu_op_decode.sv
// Combinational opcode/funct3/funct7 -> 5-bit ALU operation code
// for R-type, I-type, branch and LUI instructions.
module multicycle_control_alu_op_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [4:0] op
);

    logic is_r;
    logic is_i;
    logic is_br;
    logic is_lui;
    logic m_ext;
    logic alt;

    assign is_r   = opcode == OPC_RTYPE;
    assign is_i   = opcode == OPC_IMM;
    assign is_br  = opcode == OPC_BRANCH;
    assign is_lui = opcode == OPC_LUI;
    assign m_ext  = funct7 == 7'b0000001;
    assign alt    = funct7[5];

    function automatic logic [4:0] base_op(
        input logic [2:0] f3,
        input logic       sub,
        input logic       sra
    );
        logic [4:0] r;
        case (f3)
            3'b000: r = sub ? OPSUB : OPADD;
            3'b001: r = OPSLL;
            3'b010: r = OPSLT;
            3'b011: r = OPSLTU;
            3'b100: r = OPXOR;
            3'b101: r = sra ? OPSRA : OPSRL;
            3'b110: r = OPOR;
            3'b111: r = OPAND;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] mul_op(input logic [2:0] f3);
        logic [4:0] r;
        case (f3)
            3'b000: r = OPMUL;
            3'b001: r = OPMULH;
            3'b010: r = OPMULHSU;
            3'b011: r = OPMULHU;
            3'b100: r = OPDIV;
            3'b101: r = OPDIVU;
            3'b110: r = OPREM;
            3'b111: r = OPREMU;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] br_op(input logic [2:0] f3);
        logic [4:0] r;
        case (f3)
            3'b000:  r = OPBEQ;
            3'b001:  r = OPBNE;
            3'b100:  r = OPSLT;
            3'b101:  r = OPGE;
            3'b110:  r = OPSLTU;
            3'b111:  r = OPGEU;
            default: r = OPADD;
        endcase
        return r;
    endfunction

    // I-type never subtracts; funct7[5] only selects SRAI
    always_comb begin
        op = OPADD;
        unique case (1'b1)
            is_r && m_ext:  op = mul_op(funct3);
            is_r && !m_ext: op = base_op(funct3, alt, alt);
            is_i:           op = base_op(funct3, 1'b0, alt);
            is_br:          op = br_op(funct3);
            is_lui:         op = OPLUI;
            default:        op = OPADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32IM control FSM: sequences fetch/decode/execute/
// memory/writeback and drives ALU op plus datapath enables.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int DIV_LATENCY = 8,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    multicycle_control_if.master bus
);

    localparam logic [7:0]  DIV_LOAD = 8'(DIV_LATENCY - 1);
    localparam bit          TO_EN    = (MEM_TIMEOUT != 0);
    localparam logic [15:0] TO_LAST  = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      state_n;
    logic        run;
    logic [7:0]  dcnt;
    logic [7:0]  dcnt_n;
    logic [15:0] wcnt;
    logic [15:0] wcnt_n;
    logic        timed_out;
    logic [4:0]  dec_op;
    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        unused_instr;

    assign opc          = bus.iInstr[6:0];
    assign funct3       = bus.iInstr[14:12];
    assign funct7       = bus.iInstr[31:25];
    assign unused_instr = ^{bus.iInstr[24:15], bus.iInstr[11:7]};

    multicycle_control_alu_op_decode u_dec (
        .opcode (opc),
        .funct3 (funct3),
        .funct7 (funct7),
        .op     (dec_op)
    );

    assign timed_out = TO_EN && (wcnt == TO_LAST);

    // run rises one edge after reset release; until then nothing is enabled
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            run   <= 1'b0;
            state <= S_FETCH;
            dcnt  <= '0;
            wcnt  <= '0;
        end else begin
            run   <= 1'b1;
            state <= state_n;
            dcnt  <= dcnt_n;
            wcnt  <= wcnt_n;
        end
    end

    always_comb begin
        state_n         = state;
        dcnt_n          = dcnt;
        wcnt_n          = '0;
        bus.oALUControl = OPADD;
        bus.oALUSrcA    = 2'd0;
        bus.oALUSrcB    = 2'd0;
        bus.oIRWrite    = 1'b0;
        bus.oPCWrite    = 1'b0;
        bus.oPCSource   = 1'b0;
        bus.oMemRead    = 1'b0;
        bus.oMemWrite   = 1'b0;
        bus.oIorD       = 1'b0;
        bus.oRegWrite   = 1'b0;
        bus.oMemtoReg   = 2'd0;
        if (run) begin
            unique case (state)
                S_FETCH: begin
                    bus.oMemRead = 1'b1;
                    bus.oALUSrcB = 2'd1;
                    if (bus.iMemReady) begin
                        bus.oIRWrite = 1'b1;
                        bus.oPCWrite = 1'b1;
                        state_n      = S_DECODE;
                    end else if (timed_out) begin
                        state_n = S_ILLEGAL;
                    end else begin
                        wcnt_n = wcnt + 16'd1;
                    end
                end
                S_DECODE: begin
                    bus.oALUSrcA = 2'd2;
                    bus.oALUSrcB = 2'd2;
                    case (opc)
                        OPC_RTYPE: begin
                            state_n = S_EXEC_R;
                            dcnt_n  = DIV_LOAD;
                        end
                        OPC_IMM:    state_n = S_EXEC_I;
                        OPC_LOAD:   state_n = S_MEM_ADDR;
                        OPC_STORE:  state_n = S_MEM_ADDR;
                        OPC_BRANCH: state_n = S_BRANCH;
                        OPC_JAL:    state_n = S_JAL;
                        OPC_JALR:   state_n = S_JALR;
                        OPC_LUI:    state_n = S_LUI;
                        default:    state_n = S_ILLEGAL;
                    endcase
                end
                S_EXEC_R: begin
                    bus.oALUSrcA    = 2'd1;
                    bus.oALUControl = dec_op;
                    if (is_div_op(dec_op) && dcnt != 8'd0) begin
                        dcnt_n = dcnt - 8'd1;
                    end else begin
                        state_n = S_WB_ALU;
                    end
                end
                S_EXEC_I: begin
                    bus.oALUSrcA    = 2'd1;
                    bus.oALUSrcB    = 2'd2;
                    bus.oALUControl = dec_op;
                    state_n         = S_WB_ALU;
                end
                S_WB_ALU: begin
                    bus.oRegWrite = 1'b1;
                    state_n       = S_FETCH;
                end
                S_MEM_ADDR: begin
                    bus.oALUSrcA = 2'd1;
                    bus.oALUSrcB = 2'd2;
                    state_n = (opc == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    bus.oMemRead = 1'b1;
                    bus.oIorD    = 1'b1;
                    if (bus.iMemReady) begin
                        state_n = S_WB_MEM;
                    end else if (timed_out) begin
                        state_n = S_ILLEGAL;
                    end else begin
                        wcnt_n = wcnt + 16'd1;
                    end
                end
                S_WB_MEM: begin
                    bus.oRegWrite = 1'b1;
                    bus.oMemtoReg = 2'd1;
                    state_n       = S_FETCH;
                end
                S_MEM_WR: begin
                    bus.oMemWrite = 1'b1;
                    bus.oIorD     = 1'b1;
                    if (bus.iMemReady) begin
                        state_n = S_FETCH;
                    end else if (timed_out) begin
                        state_n = S_ILLEGAL;
                    end else begin
                        wcnt_n = wcnt + 16'd1;
                    end
                end
                S_BRANCH: begin
                    bus.oALUSrcA    = 2'd1;
                    bus.oALUControl = dec_op;
                    if (funct3 inside {3'b010, 3'b011}) begin
                        state_n = S_ILLEGAL;
                    end else begin
                        bus.oPCWrite  = ~bus.iZero;
                        bus.oPCSource = 1'b1;
                        state_n       = S_FETCH;
                    end
                end
                S_JAL: begin
                    bus.oRegWrite = 1'b1;
                    bus.oMemtoReg = 2'd2;
                    bus.oPCWrite  = 1'b1;
                    bus.oPCSource = 1'b1;
                    state_n       = S_FETCH;
                end
                S_JALR: begin
                    bus.oALUSrcA  = 2'd1;
                    bus.oALUSrcB  = 2'd2;
                    bus.oPCWrite  = 1'b1;
                    bus.oRegWrite = 1'b1;
                    bus.oMemtoReg = 2'd2;
                    state_n       = S_FETCH;
                end
                S_LUI: begin
                    bus.oALUSrcB    = 2'd2;
                    bus.oALUControl = OPLUI;
                    state_n         = S_WB_ALU;
                end
                S_ILLEGAL: state_n = S_ILLEGAL;
                default:   state_n = S_ILLEGAL;
            endcase
        end
    end

    assign bus.oIllegal = (state == S_ILLEGAL);
    assign bus.oState   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction table with per-cycle
// scoreboard, plus wait-state, illegal, reset and timeout sequences.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    multicycle_control_if b ();
    multicycle_control_if bt ();

    multicycle_control #(.DIV_LATENCY(8), .MEM_TIMEOUT(0)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (b)
    );

    multicycle_control #(.DIV_LATENCY(1), .MEM_TIMEOUT(4)) dut_to (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bt)
    );

    typedef struct {
        string       nm;
        logic [31:0] ins;
        logic        z;
        int          len;
        logic [63:0] trace;
        logic [15:0] rw;
        logic [15:0] pcw;
        logic [15:0] mr;
        logic [15:0] mw;
        logic [15:0] am;
        logic [4:0]  op;
    } vec_t;

    typedef struct {
        string      nm;
        int         cyc;
        logic [3:0] st;
        logic [4:0] en;
        logic       chk_op;
        logic [4:0] op;
    } exp_t;

    vec_t tbl[16];
    exp_t sbq[$];
    vec_t v;
    exp_t e;
    logic [31:0] tr;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    endtask

    function automatic logic [4:0] en_main();
        return {b.oIRWrite, b.oPCWrite, b.oMemRead, b.oMemWrite, b.oRegWrite};
    endfunction

    function automatic logic [4:0] en_to();
        return {bt.oIRWrite, bt.oPCWrite, bt.oMemRead, bt.oMemWrite, bt.oRegWrite};
    endfunction

    task automatic start(input logic [31:0] ins, input logic z);
        @(posedge clk);
        #1;
        b.iInstr = ins;
        b.iZero = z;
        b.iMemReady = 1'b1;
        @(negedge clk);
    endtask

    task automatic step(input logic rdy);
        @(posedge clk);
        #1;
        b.iMemReady = rdy;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        // state trace: cycle 1 in the low nibble
        tbl[0]  = '{"add",  32'h002081B3, 1'b0, 4,  64'h4210, 16'h8,   16'h1, 16'h1, 16'h0, 16'h4,   OPADD};
        tbl[1]  = '{"sub",  32'h40208233, 1'b0, 4,  64'h4210, 16'h8,   16'h1, 16'h1, 16'h0, 16'h4,   OPSUB};
        tbl[2]  = '{"div",  32'h0220C333, 1'b0, 11, 64'h42222222210, 16'h400, 16'h1, 16'h1, 16'h0, 16'h3FC, OPDIV};
        tbl[3]  = '{"beq0", 32'h00208463, 1'b0, 3,  64'h910,  16'h0,   16'h5, 16'h1, 16'h0, 16'h4,   OPBEQ};
        tbl[4]  = '{"beq1", 32'h00208463, 1'b1, 3,  64'h910,  16'h0,   16'h1, 16'h1, 16'h0, 16'h4,   OPBEQ};
        tbl[5]  = '{"addi", 32'h00500093, 1'b0, 4,  64'h4310, 16'h8,   16'h1, 16'h1, 16'h0, 16'h4,   OPADD};
        tbl[6]  = '{"srai", 32'h4030D093, 1'b0, 4,  64'h4310, 16'h8,   16'h1, 16'h1, 16'h0, 16'h4,   OPSRA};
        tbl[7]  = '{"lui",  32'h123452B7, 1'b0, 4,  64'h4C10, 16'h8,   16'h1, 16'h1, 16'h0, 16'h4,   OPLUI};
        tbl[8]  = '{"jal",  32'h010000EF, 1'b0, 3,  64'hA10,  16'h4,   16'h5, 16'h1, 16'h0, 16'h0,   OPADD};
        tbl[9]  = '{"jalr", 32'h000100E7, 1'b0, 3,  64'hB10,  16'h4,   16'h5, 16'h1, 16'h0, 16'h0,   OPADD};
        tbl[10] = '{"sw",   32'h0020A223, 1'b0, 4,  64'h8510, 16'h0,   16'h1, 16'h1, 16'h8, 16'h0,   OPADD};
        tbl[11] = '{"lw",   32'h0000A283, 1'b0, 5,  64'h76510, 16'h10, 16'h1, 16'h9, 16'h0, 16'h0,   OPADD};
        tbl[12] = '{"rem",  32'h0220E3B3, 1'b0, 11, 64'h42222222210, 16'h400, 16'h1, 16'h1, 16'h0, 16'h3FC, OPREM};
        tbl[13] = '{"mul",  32'h022081B3, 1'b0, 4,  64'h4210, 16'h8,   16'h1, 16'h1, 16'h0, 16'h4,   OPMUL};
        tbl[14] = '{"bltu", 32'h0020E463, 1'b0, 3,  64'h910,  16'h0,   16'h5, 16'h1, 16'h0, 16'h4,   OPSLTU};
        tbl[15] = '{"bge1", 32'h0020D463, 1'b1, 3,  64'h910,  16'h0,   16'h1, 16'h1, 16'h0, 16'h4,   OPGE};

        b.iInstr = 32'h0;
        b.iZero = 1'b0;
        b.iMemReady = 1'b1;
        bt.iInstr = 32'h0;
        bt.iZero = 1'b0;
        bt.iMemReady = 1'b0;

        #3;
        chk("rst.state", 32'(b.oState), 32'(S_FETCH));
        chk("rst.en", 32'(en_main()), 32'h0);
        chk("rst.alu", 32'(b.oALUControl), 32'(OPADD));
        chk("rst.ill", 32'(b.oIllegal), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst.hold.en", 32'(en_main()), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            v = tbl[i];
            for (int c = 0; c < v.len; c++) begin
                e.nm = v.nm;
                e.cyc = c + 1;
                e.st = v.trace[4*c +: 4];
                e.en = {c == 0, v.pcw[c], v.mr[c], v.mw[c], v.rw[c]};
                e.chk_op = v.am[c];
                e.op = v.op;
                sbq.push_back(e);
            end
            for (int c = 0; c < v.len; c++) begin
                if (c == 0) start(v.ins, v.z);
                else step(1'b1);
                e = sbq.pop_front();
                chk($sformatf("%s.c%0d.st", e.nm, e.cyc), 32'(b.oState), 32'(e.st));
                chk($sformatf("%s.c%0d.en", e.nm, e.cyc), 32'(en_main()), 32'(e.en));
                if (e.chk_op)
                    chk($sformatf("%s.c%0d.op", e.nm, e.cyc), 32'(b.oALUControl), 32'(e.op));
            end
        end

        // load with three wait states in MEM_RD
        start(32'h0000A283, 1'b0);
        step(1'b1);
        step(1'b1);
        for (int c = 4; c <= 7; c++) begin
            step(c == 7);
            chk($sformatf("lwwait.c%0d", c), 32'({b.oState, b.oMemRead, b.oIorD, b.oRegWrite}),
                32'({S_MEM_RD, 1'b1, 1'b1, 1'b0}));
        end
        step(1'b1);
        chk("lwwait.c8", 32'({b.oState, b.oRegWrite, b.oMemtoReg}), 32'({S_WB_MEM, 1'b1, 2'd1}));
        step(1'b1);
        chk("lwwait.c9", 32'(b.oState), 32'(S_FETCH));

        // unknown opcode goes ILLEGAL and stays
        start(32'h0000007F, 1'b0);
        step(1'b1);
        for (int c = 3; c <= 5; c++) begin
            step(1'b1);
            chk($sformatf("ill.c%0d", c), 32'({b.oState, b.oIllegal, en_main()}),
                32'({S_ILLEGAL, 1'b1, 5'd0}));
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("ill.rst", 32'({b.oState, b.oIllegal}), 32'({S_FETCH, 1'b0}));
        @(negedge clk) rst_n = 1'b1;

        // reset while a store waits in MEM_WR
        start(32'h0020A223, 1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        chk("swrst.pre", 32'({b.oState, b.oMemWrite, b.oIorD}), 32'({S_MEM_WR, 1'b1, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        chk("swrst.now", 32'({b.oState, en_main(), b.oIorD, b.oALUControl}),
            32'({S_FETCH, 5'd0, 1'b0, OPADD}));
        b.iMemReady = 1'b1;
        @(negedge clk);
        chk("swrst.hold", 32'({en_main(), b.oIorD}), 32'h0);

        // timeout: MEM_TIMEOUT=4 instance vs. wait-forever instance
        b.iMemReady = 1'b0;
        bt.iMemReady = 1'b0;
        bt.iInstr = 32'h0220C333;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("to.wait.c%0d", c), 32'({bt.oState, bt.oMemRead, bt.oIllegal}),
                32'({S_FETCH, 1'b1, 1'b0}));
        end
        @(negedge clk);
        chk("to.fire", 32'({bt.oState, bt.oIllegal, en_to()}), 32'({S_ILLEGAL, 1'b1, 5'd0}));
        @(posedge clk);
        #1 bt.iMemReady = 1'b1;
        repeat (4) @(negedge clk);
        chk("to.sticky", 32'({bt.oState, bt.oIllegal}), 32'({S_ILLEGAL, 1'b1}));
        chk("nto.wait", 32'({b.oState, b.oMemRead, b.oIllegal}), 32'({S_FETCH, 1'b1, 1'b0}));

        // ready on the timeout cycle completes; then 1-cycle divide
        @(posedge clk);
        #1 rst_n = 1'b0;
        bt.iMemReady = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tr = 32'h04210000;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1 bt.iMemReady = (c >= 4);
            @(negedge clk);
            chk($sformatf("tor.c%0d.st", c), 32'(bt.oState), 32'(tr[4*(c-1) +: 4]));
            if (c == 4) chk("tor.c4.pcw", 32'(bt.oPCWrite), 32'h1);
            if (c == 6) chk("tor.c6.op", 32'(bt.oALUControl), 32'(OPDIV));
            if (c == 7) chk("tor.c7.rw", 32'(bt.oRegWrite), 32'h1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
